// File: rtl/ysyx_23060096_multicycle_seq_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_23060096_core_pkg
// Shared types and constants for the NPC multi-cycle sequencer.
//   state_e          : sequencer FSM states (3-bit encoding)
//   ERR_*            : halt cause codes reported on err_code
//   NOP_INSTR        : value loaded into IR on reset (addi x0, x0, 0)
//   DEFAULT_RESET_PC : default boot address
// ---------------------------------------------------------------------------
package ysyx_23060096_core_pkg;

  typedef enum logic [2:0] {
    S_RST      = 3'd0,
    S_IF_REQ   = 3'd1,
    S_IF_WAIT  = 3'd2,
    S_EX       = 3'd3,
    S_MEM_REQ  = 3'd4,
    S_MEM_WAIT = 3'd5,
    S_WB       = 3'd6,
    S_HALT     = 3'd7
  } state_e;

  localparam logic [1:0] ERR_EBREAK  = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_IFU_TMO = 2'd2;
  localparam logic [1:0] ERR_LSU_TMO = 2'd3;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

  // States in which the sequencer waits on an external bus handshake and
  // therefore must be guarded by the watchdog.
  function automatic logic is_bus_state(state_e s);
    return (s == S_IF_REQ) || (s == S_IF_WAIT) ||
           (s == S_MEM_REQ) || (s == S_MEM_WAIT);
  endfunction

endpackage

// File: rtl/ysyx_23060096_multicycle_seq_if.sv
// ---------------------------------------------------------------------------
// ysyx_23060096_multicycle_seq_if
// Bundles the sequencer's fetch/LSU handshakes, decode inputs and control
// outputs.
//   master : the sequencer (drives pc/ir, request valids, rf_we, halt ...)
//   slave  : memory ports + decode/datapath (drives readies, responses,
//            decode results and pc_next)
// ---------------------------------------------------------------------------
interface ysyx_23060096_multicycle_seq_if #(
  parameter int CNT_W = 64
);
  logic [31:0]      pc;
  logic [31:0]      ir;
  logic             ifu_req_valid;
  logic             ifu_req_ready;
  logic             ifu_rsp_valid;
  logic [31:0]      ifu_rdata;
  logic             dec_mem_rd;
  logic             dec_mem_wr;
  logic             dec_reg_wr;
  logic             dec_ebreak;
  logic             dec_illegal;
  logic [31:0]      pc_next;
  logic             lsu_req_valid;
  logic             lsu_req_wr;
  logic             lsu_req_ready;
  logic             lsu_rsp_valid;
  logic             ld_capture;
  logic             rf_we;
  logic             halt;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] instret;

  modport master (
    output pc, ir, ifu_req_valid, lsu_req_valid, lsu_req_wr,
           ld_capture, rf_we, halt, err_code, instret,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rdata,
           dec_mem_rd, dec_mem_wr, dec_reg_wr, dec_ebreak, dec_illegal,
           pc_next, lsu_req_ready, lsu_rsp_valid
  );

  modport slave (
    input  pc, ir, ifu_req_valid, lsu_req_valid, lsu_req_wr,
           ld_capture, rf_we, halt, err_code, instret,
    output ifu_req_ready, ifu_rsp_valid, ifu_rdata,
           dec_mem_rd, dec_mem_wr, dec_reg_wr, dec_ebreak, dec_illegal,
           pc_next, lsu_req_ready, lsu_rsp_valid
  );

endinterface

// File: rtl/ysyx_23060096_multicycle_seq_bus_wdog.sv
// ---------------------------------------------------------------------------
// ysyx_23060096_bus_wdog
// Counts cycles spent waiting on a bus handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : restart count from zero next cycle (has priority)
//   en_i       : count this cycle
//   expire_o   : count reached TIMEOUT-1 while enabled (never if TIMEOUT=0)
// ---------------------------------------------------------------------------
module ysyx_23060096_bus_wdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int LIMIT = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  logic [W-1:0] cnt_q, cnt_d;

  // Counting stops at the limit so the counter can never wrap back to zero
  // while the sequencer is still sitting in the same wait state.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expire_o) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (TIMEOUT != 0) && en_i && (cnt_q == W'(LIMIT));

endmodule

// File: rtl/ysyx_23060096_multicycle_seq.sv
// ---------------------------------------------------------------------------
// ysyx_23060096_multicycle_seq
// Multi-cycle instruction sequencer: owns PC/IR, issues fetch and load/store
// requests, gates register-file writes so each instruction commits once, and
// halts on ebreak, illegal instruction or bus timeout.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : master side of ysyx_23060096_multicycle_seq_if
// ---------------------------------------------------------------------------
module ysyx_23060096_multicycle_seq
  import ysyx_23060096_core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          TIMEOUT  = 16,
  parameter int          CNT_W    = 64
) (
  input  logic clk,
  input  logic rst_n,
  ysyx_23060096_multicycle_seq_if.master bus
);

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      ir_q, ir_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic [1:0]       err_q, err_d;
  logic             wr_q, wr_d;
  logic             tmo_expire;

  // Any state change restarts the watchdog, so each wait state gets a full
  // budget from its first cycle.
  ysyx_23060096_bus_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (state_d != state_q),
    .en_i     (is_bus_state(state_q)),
    .expire_o (tmo_expire)
  );

  // Handshake progress is checked before the watchdog so that a ready or
  // response arriving in the expiry cycle is never turned into a halt.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    instret_d = instret_q;
    err_d     = err_q;
    wr_d      = wr_q;
    case (state_q)
      S_RST: state_d = S_IF_REQ;
      S_IF_REQ: begin
        if (bus.ifu_req_ready) begin
          state_d = S_IF_WAIT;
        end else if (tmo_expire) begin
          state_d = S_HALT;
          err_d   = ERR_IFU_TMO;
        end
      end
      S_IF_WAIT: begin
        if (bus.ifu_rsp_valid) begin
          ir_d    = bus.ifu_rdata;
          state_d = S_EX;
        end else if (tmo_expire) begin
          state_d = S_HALT;
          err_d   = ERR_IFU_TMO;
        end
      end
      S_EX: begin
        if (bus.dec_illegal || (bus.dec_mem_rd && bus.dec_mem_wr)) begin
          state_d = S_HALT;
          err_d   = ERR_ILLEGAL;
        end else if (bus.dec_ebreak) begin
          state_d = S_HALT;
          err_d   = ERR_EBREAK;
        end else if (bus.dec_mem_rd || bus.dec_mem_wr) begin
          wr_d    = bus.dec_mem_wr;
          state_d = S_MEM_REQ;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM_REQ: begin
        if (bus.lsu_req_ready) begin
          state_d = S_MEM_WAIT;
        end else if (tmo_expire) begin
          state_d = S_HALT;
          err_d   = ERR_LSU_TMO;
        end
      end
      S_MEM_WAIT: begin
        if (bus.lsu_rsp_valid) begin
          state_d = S_WB;
        end else if (tmo_expire) begin
          state_d = S_HALT;
          err_d   = ERR_LSU_TMO;
        end
      end
      S_WB: begin
        pc_d      = bus.pc_next;
        instret_d = instret_q + CNT_W'(1);
        state_d   = S_IF_REQ;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RST;
      pc_q      <= RESET_PC;
      ir_q      <= NOP_INSTR;
      instret_q <= '0;
      err_q     <= ERR_EBREAK;
      wr_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      instret_q <= instret_d;
      err_q     <= err_d;
      wr_q      <= wr_d;
    end
  end

  // Direction of the memory access is latched in EX so lsu_req_wr and
  // ld_capture stay stable even if decode were to wobble later.
  assign bus.pc            = pc_q;
  assign bus.ir            = ir_q;
  assign bus.instret       = instret_q;
  assign bus.err_code      = err_q;
  assign bus.halt          = (state_q == S_HALT);
  assign bus.ifu_req_valid = (state_q == S_IF_REQ);
  assign bus.lsu_req_valid = (state_q == S_MEM_REQ);
  assign bus.lsu_req_wr    = (state_q == S_MEM_REQ) && wr_q;
  assign bus.ld_capture    = (state_q == S_MEM_WAIT) && bus.lsu_rsp_valid && !wr_q;
  assign bus.rf_we         = (state_q == S_WB) && bus.dec_reg_wr;

endmodule

// File: tb/tb_ysyx_23060096_multicycle_seq.sv
// ---------------------------------------------------------------------------
// tb_ysyx_23060096_multicycle_seq
// Drives the sequencer with randomized instruction streams and bus delays.
// The bench plays IFU, LSU and decoder. Instruction class lives in ir[2:0]:
//   0,7 alu+RegWr  1 alu no write  2 load  3 store  4 ebreak  5 illegal
//   6 load&store (illegal combo). ir[3]=1 makes pc_next a relative jump.
// ---------------------------------------------------------------------------
module tb_ysyx_23060096_multicycle_seq;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [63:0] instret;
    logic        regWr;
  } commitT;

  logic clk;
  logic rst_n;

  ysyx_23060096_multicycle_seq_if #(.CNT_W(64)) bus();

  ysyx_23060096_multicycle_seq #(
    .RESET_PC (RST_PC),
    .TIMEOUT  (16),
    .CNT_W    (64)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  int vecCount  = 0;
  int missCount = 0;

  logic [31:0] prog[$];
  logic [31:0] expFetch[$];
  logic        expLsuWr[$];
  logic        expLd[$];
  commitT      expCommit[$];
  logic [31:0] mPc;
  logic [63:0] mInstret;
  int          fetchIdx;

  int ifuReqFix = -1, ifuRspFix = -1, lsuReqFix = -1, lsuRspFix = -1;
  bit ifuStall = 0, lsuStall = 0, lsuRspHold = 0, lateRsp = 0;
  int rfWeCnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath stand-in: next PC is pc+4 or a signed word offset from ir.
  function automatic logic [31:0] nextPc(input logic [31:0] pc, input logic [31:0] ir);
    return ir[3] ? pc + {{20{ir[31]}}, ir[31:22], 2'b00} : pc + 32'd4;
  endfunction

  function automatic int pickDly(input int fix);
    return (fix >= 0) ? fix : int'($urandom_range(0, 3));
  endfunction

  function automatic logic [31:0] makeWord(input int k);
    return ($urandom() & 32'hFFFF_FFF8) | 32'(k);
  endfunction

  // Decoder stand-in keyed on the instruction class field.
  assign bus.dec_reg_wr  = (bus.ir[2:0] == 3'd0) || (bus.ir[2:0] == 3'd2) || (bus.ir[2:0] == 3'd7);
  assign bus.dec_mem_rd  = (bus.ir[2:0] == 3'd2) || (bus.ir[2:0] == 3'd6);
  assign bus.dec_mem_wr  = (bus.ir[2:0] == 3'd3) || (bus.ir[2:0] == 3'd6);
  assign bus.dec_ebreak  = (bus.ir[2:0] == 3'd4);
  assign bus.dec_illegal = (bus.ir[2:0] == 3'd5);
  assign bus.pc_next     = nextPc(bus.pc, bus.ir);

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Reference model: architectural effect of each instruction, queued in
  // the order the monitor should observe it.
  task automatic startProgram();
    prog.delete(); expFetch.delete(); expLsuWr.delete();
    expLd.delete(); expCommit.delete();
    mPc = RST_PC; mInstret = 0; fetchIdx = 0;
  endtask

  task automatic addInstr(input logic [31:0] w);
    commitT c;
    int k = int'(w[2:0]);
    prog.push_back(w);
    expFetch.push_back(mPc);
    if (k == 2) begin expLsuWr.push_back(1'b0); expLd.push_back(1'b1); end
    if (k == 3) expLsuWr.push_back(1'b1);
    c.pc = nextPc(mPc, w);
    c.instret = mInstret + 1;
    c.regWr = (k == 0) || (k == 2) || (k == 7);
    expCommit.push_back(c);
    mPc = c.pc;
    mInstret = c.instret;
  endtask

  task automatic addFinal(input logic [31:0] w);
    prog.push_back(w);
    expFetch.push_back(mPc);
  endtask

  task automatic applyStimulus(input int n, input int finalKind);
    int r;
    startProgram();
    for (int i = 0; i < n; i++) begin
      r = int'($urandom_range(0, 4));
      addInstr(makeWord((r == 4) ? 7 : r));
    end
    addFinal(makeWord(finalKind));
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic checkResetState();
    checkOutput("rst pc", bus.pc, RST_PC);
    checkOutput("rst ir", bus.ir, NOP);
    checkOutput("rst instret", bus.instret, 0);
    checkOutput("rst halt", bus.halt, 0);
    checkOutput("rst err", bus.err_code, 0);
    checkOutput("rst valids", {bus.ifu_req_valid, bus.lsu_req_valid, bus.ld_capture, bus.rf_we}, 0);
  endtask

  task automatic waitHalt(input int maxCyc);
    int c = 0;
    while (!bus.halt && c < maxCyc) begin
      @(negedge clk);
      c++;
    end
    if (!bus.halt) checkOutput("halt reached", bus.halt, 1);
  endtask

  task automatic endPhaseChecks(input logic [1:0] err);
    checkOutput("halt err_code", bus.err_code, err);
    checkOutput("halt instret", bus.instret, mInstret);
    checkOutput("halt pc", bus.pc, mPc);
    checkOutput("no rf_we in halting instr", rfWeCnt, 0);
    checkOutput("fetches left", expFetch.size(), 0);
    checkOutput("commits left", expCommit.size(), 0);
    checkOutput("loads left", expLd.size(), 0);
  endtask

  // IFU responder: accepts after a random/fixed delay, answers after another.
  initial begin
    int ifuPhase = 0;
    int ifuDly = 0;
    bus.ifu_req_ready = 1'b0;
    bus.ifu_rsp_valid = 1'b0;
    bus.ifu_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      bus.ifu_req_ready = 1'b0;
      bus.ifu_rsp_valid = 1'b0;
      if (!rst_n) begin
        ifuPhase = 0;
        ifuDly = pickDly(ifuReqFix);
      end else if (ifuPhase == 0) begin
        if (bus.ifu_req_valid && !ifuStall) begin
          if (ifuDly == 0) begin
            bus.ifu_req_ready = 1'b1;
            ifuPhase = 1;
            ifuDly = pickDly(ifuRspFix);
          end else ifuDly--;
        end
      end else begin
        if (ifuDly == 0) begin
          bus.ifu_rsp_valid = 1'b1;
          bus.ifu_rdata = (fetchIdx < prog.size()) ? prog[fetchIdx] : 32'h0000_0004;
          fetchIdx++;
          ifuPhase = 0;
          ifuDly = pickDly(ifuReqFix);
        end else ifuDly--;
      end
    end
  end

  // LSU responder, with hooks to stall, withhold the response, or inject a
  // stray response right after reset.
  initial begin
    int lsuPhase = 0;
    int lsuDly = 0;
    bus.lsu_req_ready = 1'b0;
    bus.lsu_rsp_valid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.lsu_req_ready = 1'b0;
      bus.lsu_rsp_valid = 1'b0;
      if (!rst_n) begin
        lsuPhase = 0;
        lsuDly = pickDly(lsuReqFix);
      end else if (lateRsp) begin
        bus.lsu_rsp_valid = 1'b1;
        lateRsp = 0;
      end else if (lsuPhase == 0) begin
        if (bus.lsu_req_valid && !lsuStall) begin
          if (lsuDly == 0) begin
            bus.lsu_req_ready = 1'b1;
            lsuPhase = 1;
            lsuDly = pickDly(lsuRspFix);
          end else lsuDly--;
        end
      end else if (!lsuRspHold) begin
        if (lsuDly == 0) begin
          bus.lsu_rsp_valid = 1'b1;
          lsuPhase = 0;
          lsuDly = pickDly(lsuReqFix);
        end else lsuDly--;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT shows a handshake,
  // a load capture or a retirement.
  initial begin
    logic [63:0] lastInstret = 0;
    commitT e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        lastInstret = 0;
        rfWeCnt = 0;
      end else begin
        if (bus.ifu_req_valid && bus.ifu_req_ready) begin
          if (expFetch.size() == 0) checkOutput("fetch unexpected", bus.ifu_req_valid, 0);
          else checkOutput("fetch pc", bus.pc, expFetch.pop_front());
        end
        if (bus.lsu_req_valid && bus.lsu_req_ready) begin
          if (expLsuWr.size() == 0) checkOutput("lsu req unexpected", bus.lsu_req_valid, 0);
          else checkOutput("lsu_req_wr", bus.lsu_req_wr, expLsuWr.pop_front());
        end
        if (bus.ld_capture) begin
          if (expLd.size() == 0) checkOutput("ld_capture unexpected", bus.ld_capture, 0);
          else begin
            void'(expLd.pop_front());
            checkOutput("ld_capture with rsp", bus.lsu_rsp_valid, 1);
          end
        end
        if (bus.rf_we) rfWeCnt++;
        if (bus.instret != lastInstret) begin
          if (expCommit.size() == 0) checkOutput("commit unexpected", bus.instret, lastInstret);
          else begin
            e = expCommit.pop_front();
            checkOutput("commit instret", bus.instret, e.instret);
            checkOutput("commit pc", bus.pc, e.pc);
            checkOutput("commit rf_we count", rfWeCnt, e.regWr);
          end
          rfWeCnt = 0;
          lastInstret = bus.instret;
        end
      end
    end
  end

  initial begin
    logic [31:0] fPc;
    logic [31:0] fIr;
    logic [63:0] fInst;
    int c;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checkResetState();

    // Directed: addi, then load with LSU ready after 3 and rsp 2 later.
    $display("[TB] directed timing");
    ifuReqFix = 0; ifuRspFix = 0; lsuReqFix = 3; lsuRspFix = 2;
    startProgram();
    addInstr(32'h0010_0010);
    addInstr(32'h0000_2002);
    addFinal(32'h0010_0004);
    applyReset();
    for (int cy = 1; cy <= 16; cy++) begin
      @(negedge clk);
      checkOutput($sformatf("c%0d ifu_req_valid", cy), bus.ifu_req_valid, (cy == 1 || cy == 5 || cy == 16));
      checkOutput($sformatf("c%0d lsu_req_valid", cy), bus.lsu_req_valid, (cy >= 8 && cy <= 11));
      checkOutput($sformatf("c%0d lsu_req_wr", cy), bus.lsu_req_wr, 0);
      checkOutput($sformatf("c%0d ld_capture", cy), bus.ld_capture, (cy == 14));
      checkOutput($sformatf("c%0d rf_we", cy), bus.rf_we, (cy == 4 || cy == 15));
      if (cy == 5) begin
        checkOutput("pc after addi", bus.pc, 32'h8000_0004);
        checkOutput("instret after addi", bus.instret, 1);
      end
    end
    waitHalt(200);
    endPhaseChecks(2'd0);
    ifuReqFix = -1; ifuRspFix = -1; lsuReqFix = -1; lsuRspFix = -1;

    // Random program ending in ebreak, then verify the halt is frozen.
    $display("[TB] random run, ebreak");
    applyStimulus(30, 4);
    applyReset();
    waitHalt(3000);
    endPhaseChecks(2'd0);
    fPc = bus.pc; fIr = bus.ir; fInst = bus.instret;
    repeat (20) begin
      @(negedge clk);
      checkOutput("ebreak frozen", {bus.pc, bus.ir, bus.instret[31:0], bus.halt,
                  bus.ifu_req_valid, bus.lsu_req_valid, bus.rf_we},
                  {fPc, fIr, fInst[31:0], 4'b1000});
    end

    // Random programs ending in each illegal form.
    $display("[TB] random run, illegal");
    applyStimulus(20, 5);
    applyReset();
    waitHalt(3000);
    endPhaseChecks(2'd1);
    applyStimulus(20, 6);
    applyReset();
    waitHalt(3000);
    endPhaseChecks(2'd1);

    // IFU never accepts: halt exactly after 16 cycles in IF_REQ.
    $display("[TB] ifu timeout");
    ifuStall = 1;
    startProgram();
    applyReset();
    for (int cy = 1; cy <= 17; cy++) begin
      @(negedge clk);
      if (cy == 16) checkOutput("halt before expiry", bus.halt, 0);
      if (cy == 17) begin
        checkOutput("halt at expiry", bus.halt, 1);
        checkOutput("ifu timeout err", bus.err_code, 2);
      end
    end
    repeat (100) begin
      @(negedge clk);
      checkOutput("ifu tmo frozen", {bus.pc, bus.ir, bus.instret[31:0], bus.halt,
                  bus.ifu_req_valid, bus.lsu_req_valid, bus.rf_we, bus.err_code},
                  {RST_PC, NOP, 32'h0, 4'b1000, 2'd2});
    end
    ifuStall = 0;

    // LSU never accepts the load.
    $display("[TB] lsu timeout");
    lsuStall = 1;
    startProgram();
    addFinal(makeWord(2));
    applyReset();
    waitHalt(500);
    endPhaseChecks(2'd3);
    lsuStall = 0;

    // Reset in MEM_WAIT, then a stray response, then a clean random run.
    $display("[TB] reset during mem wait");
    lsuRspHold = 1;
    startProgram();
    addFinal(makeWord(2));
    expLsuWr.push_back(1'b0);
    applyReset();
    c = 0;
    while (!(bus.lsu_req_valid && bus.lsu_req_ready) && c < 200) begin
      @(negedge clk);
      c++;
    end
    checkOutput("lsu accept seen", bus.lsu_req_valid && bus.lsu_req_ready, 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkResetState();
    repeat (2) @(negedge clk);
    lsuRspHold = 0;
    applyStimulus(15, 4);
    lateRsp = 1;
    rst_n = 1'b1;
    waitHalt(3000);
    endPhaseChecks(2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
